// File: rtl/outport_display.sv
`default_nettype none
// outport_display: latches CPU outport writes and scans them onto NUM_DIGITS
// multiplexed seven-segment digits in hex or decimal (sequential shift-add-3).
module outport_display #(
   parameter int NUM_DIGITS = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SCAN_DIV   = 50000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_write,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_mode,
   input  logic                  in_blank_lz,
   output logic                  out_busy,
   output logic                  out_overflow,
   output logic [7:0]            out_seg,
   output logic [NUM_DIGITS-1:0] out_digit_en
);

   localparam int BCD_DIGITS = (DATA_WIDTH * 77) / 256 + 1;
   localparam int BCD_W      = BCD_DIGITS * 4;
   localparam int NIBS       = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
   localparam int CNT_W      = $clog2(DATA_WIDTH);
   localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CONVERT = 2'd1;
   localparam logic [1:0] S_COMMIT  = 2'd2;

   localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);
   localparam logic [NUM_DIGITS-1:0] EN_RST = ACTIVE_LOW ? ~EN_ONE : EN_ONE;
   localparam logic [7:0]            SEG_RST = ACTIVE_LOW ? 8'hC0 : 8'h3F;

   logic [1:0]              r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [DATA_WIDTH-1:0]   r_shreg;
   logic [BCD_W-1:0]        r_bcd;
   logic                    r_job_mode, r_job_blz;
   logic                    r_pend_valid, r_pend_mode, r_pend_blz;
   logic [DATA_WIDTH-1:0]   r_pend_data;
   logic [NUM_DIGITS*4-1:0] r_disp;
   logic                    r_disp_blz, r_disp_ovf;
   logic [SCAN_W-1:0]       r_scan_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [7:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_en;

   logic                    w_start, w_start_mode, w_start_blz;
   logic [DATA_WIDTH-1:0]   w_start_data;
   logic [BCD_W-1:0]        w_bcd_adj;
   logic [NIBS*4-1:0]       w_src;
   logic                    w_ovf;
   logic [3:0]              w_nib;
   logic                    w_upper_nz;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic [7:0]              w_code, w_glyph;

   // A COMMIT cycle chains straight into the next job: pending first, else a fresh write.
   always_comb begin
      w_start      = 1'b0;
      w_start_data = in_data;
      w_start_mode = in_mode;
      w_start_blz  = in_blank_lz;
      if (r_state == S_IDLE) begin
         w_start = in_write;
      end else if (r_state == S_COMMIT) begin
         if (r_pend_valid) begin
            w_start      = 1'b1;
            w_start_data = r_pend_data;
            w_start_mode = r_pend_mode;
            w_start_blz  = r_pend_blz;
         end else begin
            w_start = in_write;
         end
      end
   end

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_src = '0;
      if (r_job_mode) w_src[BCD_W-1:0] = r_bcd;
      else            w_src[DATA_WIDTH-1:0] = r_shreg;
      w_ovf = 1'b0;
      for (int i = NUM_DIGITS; i < NIBS; i++) begin
         if (w_src[4*i +: 4] != 4'd0) w_ovf = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_shreg      <= '0;
         r_bcd        <= '0;
         r_job_mode   <= 1'b0;
         r_job_blz    <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_data  <= '0;
         r_pend_mode  <= 1'b0;
         r_pend_blz   <= 1'b0;
         r_disp       <= '0;
         r_disp_blz   <= 1'b0;
         r_disp_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_CONVERT: begin
               r_shreg <= r_shreg << 1;
               r_bcd   <= (w_bcd_adj << 1) | BCD_W'(r_shreg[DATA_WIDTH-1]);
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(DATA_WIDTH - 1)) r_state <= S_COMMIT;
               if (in_write) begin
                  r_pend_valid <= 1'b1;
                  r_pend_data  <= in_data;
                  r_pend_mode  <= in_mode;
                  r_pend_blz   <= in_blank_lz;
               end
            end
            S_COMMIT: begin
               r_disp     <= w_src[NUM_DIGITS*4-1:0];
               r_disp_blz <= r_job_blz;
               r_disp_ovf <= w_ovf;
               r_state    <= S_IDLE;
               if (r_pend_valid) begin
                  r_pend_valid <= in_write;
                  if (in_write) begin
                     r_pend_data <= in_data;
                     r_pend_mode <= in_mode;
                     r_pend_blz  <= in_blank_lz;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_start) begin
            r_shreg    <= w_start_data;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_job_mode <= w_start_mode;
            r_job_blz  <= w_start_blz;
            r_state    <= w_start_mode ? S_CONVERT : S_COMMIT;
         end
      end
   end

   always_comb begin
      w_nib      = 4'd0;
      w_upper_nz = 1'b0;
      w_onehot   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib       = r_disp[4*i +: 4];
            w_onehot[i] = 1'b1;
         end
         if (IDX_W'(i) >= r_idx && r_disp[4*i +: 4] != 4'd0) w_upper_nz = 1'b1;
      end
   end

   always_comb begin
      case (w_nib)
         4'h0: w_code = 8'h3F;  4'h1: w_code = 8'h06;
         4'h2: w_code = 8'h5B;  4'h3: w_code = 8'h4F;
         4'h4: w_code = 8'h66;  4'h5: w_code = 8'h6D;
         4'h6: w_code = 8'h7D;  4'h7: w_code = 8'h07;
         4'h8: w_code = 8'h7F;  4'h9: w_code = 8'h6F;
         4'hA: w_code = 8'h77;  4'hB: w_code = 8'h7C;
         4'hC: w_code = 8'h39;  4'hD: w_code = 8'h5E;
         4'hE: w_code = 8'h79;  default: w_code = 8'h71;
      endcase
      if (r_disp_ovf)                                     w_glyph = 8'h40;
      else if (r_disp_blz && r_idx != '0 && !w_upper_nz)  w_glyph = 8'h00;
      else                                                w_glyph = w_code;
   end

   // Scan runs free of the FSM; a commit simply shows up on the next registered sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
         r_seg      <= SEG_RST;
         r_en       <= EN_RST;
      end else begin
         r_seg <= ACTIVE_LOW ? ~w_glyph : w_glyph;
         r_en  <= ACTIVE_LOW ? ~w_onehot : w_onehot;
         if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
      end
   end

   assign out_busy     = (r_state != S_IDLE) | r_pend_valid;
   assign out_overflow = r_disp_ovf;
   assign out_seg      = r_seg;
   assign out_digit_en = r_en;

endmodule
`default_nettype wire
